moore_fsm_table: RTL

- Parametrised, run-time programmable Moore state machine; successor to the fixed, generator-emitted Moore FSMs.
- Next-state and output behaviour live in register tables loaded over a config port, so one netlist can run any SAT-synthesised FSM up to N_STATES states and IN_W input bits.
- Sits between the FSM generator/loader and the design under test; the generator emits a table image instead of RTL.

---
 rtl/moore_fsm_table.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/moore_fsm_table.sv
// -----------------------------------------------------------------------------
// moore_fsm_table
//   Run-time programmable Moore state machine. The next-state function and the
//   output function are held in flop-based tables that a loader writes over a
//   simple config port. One netlist can therefore execute any generated FSM of
//   up to N_STATES states and IN_W input bits.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   en         step enable; the state advances only when 1
//   in         input symbol, sampled at the clk edge when en=1
//   out        Moore output, out_tab[state_reg] (no in->out path)
//   state      current state register
//   cfg_we     table write strobe
//   cfg_sel    0 = transition table, 1 = output table
//   cfg_addr   {state, symbol} for the transition table; the low ST_W bits
//              select the output-table entry
//   cfg_wdata  low ST_W bits = next state, or low OUT_W bits = output value
//   cfg_err    one-cycle pulse after a rejected config write
//   trace_cnt  (FSM_TRACE_EN only) saturating count of state-changing steps
//   trace_chg  (FSM_TRACE_EN only) pulse in the cycle after a state change
//
// Optional build macro: FSM_TRACE_EN adds the trace_cnt / trace_chg outputs.
// -----------------------------------------------------------------------------
module moore_fsm_table #(
  parameter int IN_W        = 2,
  parameter int OUT_W       = 2,
  parameter int N_STATES    = 8,
  parameter int RESET_STATE = 0,
  localparam int ST_W = (N_STATES > 1) ? $clog2(N_STATES) : 1,
  localparam int DW   = (ST_W > OUT_W) ? ST_W : OUT_W,
  localparam int AW   = ST_W + IN_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [IN_W-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic [ST_W-1:0] state,
  input  logic            cfg_we,
  input  logic            cfg_sel,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [DW-1:0]   cfg_wdata,
  output logic            cfg_err
`ifdef FSM_TRACE_EN
  ,
  output logic [15:0]     trace_cnt,
  output logic [0:0]      trace_chg
`endif
);

  localparam int N_SYM = 1 << IN_W;

  // An index is legal only if it names one of the N_STATES states; the
  // comparison is widened so non-power-of-two state counts work.
  function automatic logic state_ok(input logic [ST_W-1:0] v);
    return (32'(v) < 32'(N_STATES));
  endfunction

  logic [ST_W-1:0]  trans_tab [N_STATES][N_SYM];
  logic [OUT_W-1:0] out_tab   [N_STATES];
  logic [ST_W-1:0]  state_reg;
  logic [ST_W-1:0]  next_state;
  logic             wr_ok;

  logic [ST_W-1:0]  addr_st;
  logic [IN_W-1:0]  addr_sym;
  logic [ST_W-1:0]  addr_out;

  assign addr_st  = cfg_addr[AW-1:IN_W];
  assign addr_sym = cfg_addr[IN_W-1:0];
  assign addr_out = cfg_addr[ST_W-1:0];

  // Next-state lookup and config-write legality check.
  always_comb begin
    next_state = state_reg;
    wr_ok      = 1'b0;
    if (en) begin
      next_state = trans_tab[state_reg][in];
    end else begin
      next_state = state_reg;
    end
    // A transition entry must sit in a legal state row and point at a legal
    // state, which keeps state_reg inside 0..N_STATES-1 forever.
    if (cfg_sel == 1'b0) begin
      wr_ok = state_ok(addr_st) && state_ok(cfg_wdata[ST_W-1:0]);
    end else begin
      wr_ok = state_ok(addr_out);
    end
  end

  // State register, error pulse and table storage; reset restores self-loops
  // and zero outputs so an unprogrammed machine parks in RESET_STATE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_W'(RESET_STATE);
      cfg_err   <= 1'b0;
      for (int s = 0; s < N_STATES; s++) begin
        out_tab[s] <= '0;
        for (int i = 0; i < N_SYM; i++) begin
          trans_tab[s][i] <= ST_W'(s);
        end
      end
    end else begin
      // Non-blocking update: a step in the same cycle as a write sees the
      // pre-write table contents.
      state_reg <= next_state;
      cfg_err   <= cfg_we && !wr_ok;
      if (cfg_we && wr_ok) begin
        if (cfg_sel == 1'b0) begin
          trans_tab[addr_st][addr_sym] <= cfg_wdata[ST_W-1:0];
        end else begin
          out_tab[addr_out] <= cfg_wdata[OUT_W-1:0];
        end
      end
    end
  end

  // Pure Moore output: a function of the state register only.
  always_comb begin
    out   = out_tab[state_reg];
    state = state_reg;
  end

`ifdef FSM_TRACE_EN
  // Count state-changing steps (saturating) and flag each one for a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_cnt <= 16'h0000;
      trace_chg <= 1'b0;
    end else begin
      if (en && (next_state != state_reg)) begin
        trace_chg <= 1'b1;
        if (trace_cnt != 16'hFFFF) begin
          trace_cnt <= trace_cnt + 16'h0001;
        end
      end else begin
        trace_chg <= 1'b0;
      end
    end
  end
`endif

endmodule
